// File: rtl/pc_lut_prog_if.sv
// Bus bundle for the programmable branch-target table: lookup request/response,
// loader write port, invalidate pulse and busy status.
interface pc_lut_prog_if #(
  parameter int TAG_W  = 8,
  parameter int ADDR_W = 12
);
  logic              inv_all;
  logic              lk_valid;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_ready;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_target;
  logic              rsp_hit;
  logic              wr_en;
  logic [TAG_W-1:0]  wr_tag;
  logic [ADDR_W-1:0] wr_target;
  logic              wr_ready;
  logic              busy;

  modport master (
    output inv_all, lk_valid, lk_tag, wr_en, wr_tag, wr_target,
    input  lk_ready, rsp_valid, rsp_target, rsp_hit, wr_ready, busy
  );

  modport slave (
    input  inv_all, lk_valid, lk_tag, wr_en, wr_tag, wr_target,
    output lk_ready, rsp_valid, rsp_target, rsp_hit, wr_ready, busy
  );
endinterface

// File: rtl/pc_lut_prog.sv
// Programmable branch-target table. Decode presents a tag, the block answers one
// cycle later with the stored target and a hit flag. Entries are loaded at runtime
// through the write port; reset and inv_all clear every valid bit by sweeping the
// table one entry per cycle, during which the block refuses traffic.
module pc_lut_prog #(
  parameter int                TAG_W          = 8,
  parameter int                ADDR_W         = 12,
  parameter int                DEPTH          = 256,
  parameter logic [ADDR_W-1:0] DEFAULT_TARGET = '0
) (
  input  logic         clk,
  input  logic         reset,
  pc_lut_prog_if.slave bus
);

  // Storage is rounded up to a power of two so the index is a plain tag slice;
  // entries at or above DEPTH are never written and never read.
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                TBL_N   = 2 ** IDX_W;
  localparam logic [TAG_W:0]    DEPTH_X = (TAG_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ctr, ctr_nxt;

  logic [ADDR_W-1:0] tbl [TBL_N];
  logic [TBL_N-1:0]  vld;

  logic              lk_acc, wr_acc, lk_in, wr_in, bypass;
  logic [IDX_W-1:0]  lk_idx, wr_idx;

  logic              rsp_vld_p1;
  logic [ADDR_W-1:0] rsp_target_p1;
  logic              rsp_hit_p1;

  assign bus.lk_ready = (state == RUN) & ~bus.inv_all;
  assign bus.wr_ready = (state == RUN) & ~bus.inv_all;
  assign bus.busy     = (state == CLEAR);

  assign lk_acc = bus.lk_valid & bus.lk_ready;
  assign wr_acc = bus.wr_en & bus.wr_ready;
  assign lk_in  = ({1'b0, bus.lk_tag} < DEPTH_X);
  assign wr_in  = ({1'b0, bus.wr_tag} < DEPTH_X);
  assign lk_idx = bus.lk_tag[IDX_W-1:0];
  assign wr_idx = bus.wr_tag[IDX_W-1:0];
  // A write landing on the same edge as a lookup of the same tag is forwarded.
  assign bypass = wr_acc & wr_in & (bus.wr_tag == bus.lk_tag);

  // State and sweep-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ctr   <= '0;
    end else begin
      state <= state_nxt;
      ctr   <= ctr_nxt;
    end
  end

  // Next state: sweep DEPTH entries in CLEAR, inv_all restarts the sweep from 0.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    case (state)
      CLEAR: begin
        if (bus.inv_all) begin
          ctr_nxt = '0;
        end else if (ctr == LAST) begin
          state_nxt = RUN;
          ctr_nxt   = '0;
        end else begin
          ctr_nxt = ctr + IDX_W'(1);
        end
      end
      RUN: begin
        if (bus.inv_all) begin
          state_nxt = CLEAR;
          ctr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ctr_nxt   = '0;
      end
    endcase
  end

  // Valid bits: cleared one per cycle by the sweep, set by accepted in-range writes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      vld[ctr] <= 1'b0;
    end else if (wr_acc && wr_in) begin
      vld[wr_idx] <= 1'b1;
    end
  end

  // Target storage: written on accepted in-range writes only.
  always_ff @(posedge clk) begin
    if (wr_acc && wr_in) begin
      tbl[wr_idx] <= bus.wr_target;
    end
  end

  // ---- stage p1: registered lookup response ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_p1    <= 1'b0;
      rsp_target_p1 <= DEFAULT_TARGET;
      rsp_hit_p1    <= 1'b0;
    end else begin
      rsp_vld_p1 <= lk_acc;
      if (lk_acc) begin
        if (bypass) begin
          rsp_target_p1 <= bus.wr_target;
          rsp_hit_p1    <= 1'b1;
        end else if (lk_in && vld[lk_idx]) begin
          rsp_target_p1 <= tbl[lk_idx];
          rsp_hit_p1    <= 1'b1;
        end else begin
          rsp_target_p1 <= DEFAULT_TARGET;
          rsp_hit_p1    <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid  = rsp_vld_p1;
  assign bus.rsp_target = rsp_target_p1;
  assign bus.rsp_hit    = rsp_hit_p1;

endmodule
